// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions (active-low, index 0 = segment a) and the
// scan decoder's FSM state type.
package seg7_pkg;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_P     = 7'b0011000;
    localparam logic [0:6] SEG_L     = 7'b1110001;
    localparam logic [0:6] SEG_A     = 7'b0001000;
    localparam logic [0:6] SEG_Y     = 7'b1000100;
    localparam logic [0:6] SEG_H     = 7'b1001000;
    localparam logic [0:6] SEG_DASH  = 7'b1111110;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {WAIT, SETTLE, HOLD} scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-low segment pattern to its 4-bit code.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [0:6] seg,
    output logic [3:0] code,
    output logic       hit,
    output logic       blank
);

    always_comb begin
        code  = 4'd0;
        hit   = 1'b1;
        blank = 1'b0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_P:     code = 4'd10;
            SEG_L:     code = 4'd11;
            SEG_A:     code = 4'd12;
            SEG_Y:     code = 4'd13;
            SEG_H:     code = 4'd14;
            SEG_DASH:  code = 4'd15;
            SEG_BLANK: begin
                hit   = 1'b0;
                blank = 1'b1;
            end
            default:   hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and recovers the code shown
// on each digit once its (digit, segments) pair has been stable long enough.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [0:6]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] code_out,
    output logic [NUM_DIGITS-1:0]   valid_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    update
);

    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

    logic [0:6]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] an_s1, an_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            an_s1  <= an_in;
            an_s2  <= an_s1;
        end
    end

    // A select exists only when exactly one enable is low.
    logic [SEL_W-1:0] sel_idx;
    logic             sel_vld;
    logic [3:0]       nlow;

    always_comb begin
        sel_idx = '0;
        nlow    = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s2[i]) begin
                nlow    = nlow + 4'd1;
                sel_idx = SEL_W'(i);
            end
        end
        sel_vld = (nlow == 4'd1);
    end

    logic [3:0] dec_code;
    logic       dec_hit, dec_blank;

    seg7_pattern_decode u_dec (
        .seg   (seg_s2),
        .code  (dec_code),
        .hit   (dec_hit),
        .blank (dec_blank)
    );

    scan_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [SEL_W-1:0] ref_sel;
    logic [0:6]       ref_seg;
    logic             load, capture, same;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WAIT;
            cnt     <= '0;
            ref_sel <= '0;
            ref_seg <= '1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load) begin
                ref_sel <= sel_idx;
                ref_seg <= seg_s2;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        capture = 1'b0;
        same    = (sel_idx == ref_sel) && (seg_s2 == ref_seg);
        cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
        if (!sel_vld) begin
            state_n = WAIT;
            cnt_n   = '0;
        end else begin
            case (state)
                WAIT: begin
                    state_n = SETTLE;
                    cnt_n   = CNT_W'(1);
                    load    = 1'b1;
                end
                SETTLE: begin
                    if (!same) begin
                        cnt_n = CNT_W'(1);
                        load  = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= STABLE) begin
                            capture = 1'b1;
                            state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!same) begin
                        state_n = SETTLE;
                        cnt_n   = CNT_W'(1);
                        load    = 1'b1;
                    end
                end
                default: begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Blank and unrecognised captures keep the last good code on that digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_out  <= '0;
            valid_out <= '0;
            err_out   <= '0;
            blank_out <= '0;
            update    <= 1'b0;
        end else begin
            update <= capture;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (capture && sel_idx == SEL_W'(d)) begin
                    if (dec_hit) code_out[4*d +: 4] <= dec_code;
                    valid_out[d] <= dec_hit;
                    err_out[d]   <= !dec_hit && !dec_blank;
                    blank_out[d] <= dec_blank;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: a reference model pushes expected
// output snapshots on each dwell, popped and compared on every update pulse.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [0:6]    seg_in;
    logic [ND-1:0] an_in;
    logic [4*ND-1:0] code_out;
    logic [ND-1:0] valid_out, err_out, blank_out;
    logic          update;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .an_in     (an_in),
        .code_out  (code_out),
        .valid_out (valid_out),
        .err_out   (err_out),
        .blank_out (blank_out),
        .update    (update)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*ND-1:0] code;
        logic [ND-1:0]   valid;
        logic [ND-1:0]   err;
        logic [ND-1:0]   blank;
    } exp_t;

    localparam logic [0:6] PAT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0011000, 7'b1110001,
        7'b0001000, 7'b1000100, 7'b1001000, 7'b1111110
    };

    exp_t       sbq[$];
    exp_t       m;
    int         vectors = 0;
    int         miscompares = 0;
    int         ups = 0;
    logic       last_vld;
    int         last_dig;
    logic [0:6] last_seg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m.code  = '0;
        m.valid = '0;
        m.err   = '0;
        m.blank = '0;
        sbq.delete();
        last_vld = 1'b0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_code"},  32'(code_out),  32'(m.code));
        chk({tag, "_valid"}, 32'(valid_out), 32'(m.valid));
        chk({tag, "_err"},   32'(err_out),   32'(m.err));
        chk({tag, "_blank"}, 32'(blank_out), 32'(m.blank));
    endtask

    // Drive one (digit, segments) pair just after a rising edge and hold it.
    task automatic dwell(input string tag, input int dig, input logic [0:6] seg,
                         input logic [ND-1:0] an, input int cycles);
        int   nlow;
        logic sel_ok, expect_cap, found;
        int   code;
        exp_t e, got;
        seg_in = seg;
        an_in  = an;
        nlow = 0;
        for (int i = 0; i < ND; i++) if (!an[i]) nlow++;
        sel_ok = (nlow == 1);
        expect_cap = sel_ok && cycles >= S + 2 &&
                     !(last_vld && last_dig == dig && last_seg == seg);
        if (expect_cap) begin
            found = 1'b0;
            code  = 0;
            for (int k = 0; k < 16; k++) if (PAT[k] == seg) begin found = 1'b1; code = k; end
            if (found) begin
                m.code[4*dig +: 4] = 4'(code);
                m.valid[dig] = 1'b1; m.err[dig] = 1'b0; m.blank[dig] = 1'b0;
            end else if (seg == 7'b1111111) begin
                m.valid[dig] = 1'b0; m.err[dig] = 1'b0; m.blank[dig] = 1'b1;
            end else begin
                m.valid[dig] = 1'b0; m.err[dig] = 1'b1; m.blank[dig] = 1'b0;
            end
            e = m;
            sbq.push_back(e);
        end
        last_vld = sel_ok;
        last_dig = dig;
        last_seg = seg;
        for (int c = 1; c <= cycles; c++) begin
            @(posedge clk);
            #1;
            if (update) begin
                ups++;
                if (sbq.size() == 0) begin
                    chk({tag, "_spurious_update"}, 32'd1, 32'd0);
                end else begin
                    got = sbq.pop_front();
                    chk({tag, "_latency"}, 32'(c), 32'(S + 2));
                    chk({tag, "_code"},  32'(code_out),  32'(got.code));
                    chk({tag, "_valid"}, 32'(valid_out), 32'(got.valid));
                    chk({tag, "_err"},   32'(err_out),   32'(got.err));
                    chk({tag, "_blank"}, 32'(blank_out), 32'(got.blank));
                end
            end
        end
        chk({tag, "_pending"}, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        model_reset();
        rst    = 1'b1;
        seg_in = 7'b0000000;
        an_in  = 4'b1110;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs("reset");
        chk("reset_update", 32'(update), 32'd0);

        // Release with digit 0 showing 8: capture lands S+2 edges later.
        ups = 0;
        rst = 1'b0;
        dwell("rel8", 0, 7'b0000000, 4'b1110, 10);
        chk("rel8_updates", 32'(ups), 32'd1);

        for (int pass = 0; pass < 2; pass++) begin
            ups = 0;
            dwell("scanA", 3, 7'b0001000, 4'b0111, 16);
            dwell("scanL", 2, 7'b1110001, 4'b1011, 16);
            dwell("scanP", 1, 7'b0011000, 4'b1101, 16);
            dwell("scanY", 0, 7'b1000100, 4'b1110, 16);
            chk("scan_updates", 32'(ups), 32'd4);
            chk("scan_code",  32'(code_out),  32'h0000CBAD);
            chk("scan_valid", 32'(valid_out), 32'hF);
        end

        ups = 0;
        dwell("glitch2", 1, 7'b0010010, 4'b1101, 3);
        dwell("settle3", 1, 7'b0000110, 4'b1101, 10);
        chk("glitch_updates", 32'(ups), 32'd1);
        chk("glitch_code1", 32'(code_out[7:4]), 32'd3);

        dwell("unknown", 2, 7'b1010101, 4'b1011, 10);
        chk("unknown_code2", 32'(code_out[11:8]), 32'hB);
        dwell("blank", 2, 7'b1111111, 4'b1011, 10);

        ups = 0;
        dwell("multi", 0, 7'b0000000, 4'b1100, 20);
        dwell("none",  0, 7'b0000000, 4'b1111, 20);
        chk("nosel_updates", 32'(ups), 32'd0);
        chk_outputs("nosel");
        // Same pair as before the gap recaptures, since the FSM went back to WAIT.
        dwell("reblank", 2, 7'b1111111, 4'b1011, 10);

        // Reset two cycles into SETTLE on a fresh pair.
        dwell("pre_rst", 0, 7'b0000100, 4'b1110, 4);
        rst = 1'b1;
        model_reset();
        #1;
        chk_outputs("midrst");
        ups = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (update) ups++;
        end
        chk("midrst_updates", 32'(ups), 32'd0);
        rst = 1'b0;
        dwell("post_rst", 0, 7'b0000100, 4'b1110, 10);
        chk("post_rst_code", 32'(code_out), 32'h00000009);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
